// File: rtl/uart_rx_buffer_ctrl.sv
// UART receive buffer controller: checks parity and framing on each assembled
// byte, queues {frame_err, parity_err, data} in a FIFO, raises level and
// idle-timeout interrupts, and supervises the Rx FSM with a watchdog.
module uart_rx_buffer_ctrl #(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned AW            = 4,
  parameter int unsigned LEVEL_TH      = 8,
  parameter int unsigned TIMEOUT_TICKS = 640,
  parameter int unsigned WDG_TICKS     = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          acq_tick_i,
  input  logic [4:0]    state_i,
  input  logic          byte_valid_i,
  input  logic [7:0]    byte_data_i,
  input  logic          parity_bit_i,
  input  logic          stop_bit_i,
  input  logic          parity_enable_i,
  input  logic          parity_odd_i,
  input  logic          rd_en_i,
  output logic [9:0]    rd_data_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [AW:0]   level_o,
  output logic          overrun_o,
  input  logic          overrun_clr_i,
  output logic          irq_level_o,
  output logic          irq_timeout_o,
  output logic          wdg_rst_o
);

  localparam int unsigned LW = AW + 1;
  localparam int unsigned DW = 10;
  localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);
  localparam int unsigned WW = $clog2(WDG_TICKS + 1);

  localparam logic [4:0]    ST_INTERVAL = 5'b00001;
  localparam logic [LW-1:0] DEPTH_L     = LW'(DEPTH);
  localparam logic [LW-1:0] LEVEL_TH_L  = LW'(LEVEL_TH);
  localparam logic [TW-1:0] TIMEOUT_L   = TW'(TIMEOUT_TICKS);
  localparam logic [WW-1:0] WDG_LAST_L  = WW'(WDG_TICKS - 1);

  // Storage and registered state
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          overrun_q, overrun_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          irq_tmo_q, irq_tmo_d;
  logic [WW-1:0] wdg_cnt_q, wdg_cnt_d;
  logic          wdg_rst_q, wdg_rst_d;

  // Combinational helpers
  logic          parity_err_c;
  logic          frame_err_c;
  logic [DW-1:0] entry_c;
  logic          rd_accept_c;
  logic          wr_accept_c;
  logic          overrun_set_c;
  logic          in_interval_c;
  logic          state_legal_c;

  // Frame status checks on the incoming byte
  always_comb begin
    parity_err_c = 1'b0;
    frame_err_c  = 1'b0;
    entry_c      = '0;
    parity_err_c = parity_enable_i & ((^byte_data_i ^ parity_bit_i) != parity_odd_i);
    frame_err_c  = ~stop_bit_i;
    entry_c      = {frame_err_c, parity_err_c, byte_data_i};
  end

  // Handshake decisions; a read at full frees the slot the concurrent write uses
  always_comb begin
    rd_accept_c   = 1'b0;
    wr_accept_c   = 1'b0;
    overrun_set_c = 1'b0;
    in_interval_c = 1'b0;
    state_legal_c = 1'b0;
    rd_accept_c   = rd_en_i & ~empty_q;
    wr_accept_c   = byte_valid_i & (~full_q | rd_accept_c);
    overrun_set_c = byte_valid_i & full_q & ~rd_accept_c;
    in_interval_c = (state_i == ST_INTERVAL);
    state_legal_c = $onehot(state_i);
  end

  // FIFO pointer, level, flag and read-data next state
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    level_d   = level_q;
    empty_d   = empty_q;
    full_d    = full_q;
    overrun_d = overrun_q;
    rd_data_d = rd_data_q;

    if (wr_accept_c) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (rd_accept_c) begin
      rptr_d    = rptr_q + AW'(1);
      rd_data_d = mem_q[rptr_q];
    end

    level_d = level_q + LW'(wr_accept_c) - LW'(rd_accept_c);
    empty_d = (level_d == '0);
    full_d  = (level_d == DEPTH_L);

    // Set wins over a same-cycle clear
    if (overrun_set_c) begin
      overrun_d = 1'b1;
    end else if (overrun_clr_i) begin
      overrun_d = 1'b0;
    end
  end

  // Idle timeout: counts acq ticks while data waits and the line is idle
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    irq_tmo_d = 1'b0;
    if (wr_accept_c || rd_accept_c || (level_q == '0) || !in_interval_c) begin
      tmo_cnt_d = '0;
    end else if (acq_tick_i && (tmo_cnt_q != TIMEOUT_L)) begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    end
    irq_tmo_d = (tmo_cnt_d == TIMEOUT_L);
  end

  // Watchdog: hang outside INTERVAL pulses a reset; illegal codes hold it high
  always_comb begin
    wdg_cnt_d = wdg_cnt_q;
    wdg_rst_d = 1'b0;
    if (!state_legal_c) begin
      wdg_cnt_d = '0;
      wdg_rst_d = 1'b1;
    end else if (in_interval_c) begin
      wdg_cnt_d = '0;
    end else if (acq_tick_i) begin
      if (wdg_cnt_q == WDG_LAST_L) begin
        wdg_cnt_d = '0;
        wdg_rst_d = 1'b1;
      end else begin
        wdg_cnt_d = wdg_cnt_q + WW'(1);
      end
    end
  end

  // FIFO storage; contents are discarded on reset by clearing the pointers
  always_ff @(posedge clk) begin
    if (wr_accept_c) begin
      mem_q[wptr_q] <= entry_c;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
      rd_data_q <= '0;
      tmo_cnt_q <= '0;
      irq_tmo_q <= 1'b0;
      wdg_cnt_q <= '0;
      wdg_rst_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      overrun_q <= overrun_d;
      rd_data_q <= rd_data_d;
      tmo_cnt_q <= tmo_cnt_d;
      irq_tmo_q <= irq_tmo_d;
      wdg_cnt_q <= wdg_cnt_d;
      wdg_rst_q <= wdg_rst_d;
    end
  end

  // Output mapping
  assign rd_data_o     = rd_data_q;
  assign empty_o       = empty_q;
  assign full_o        = full_q;
  assign level_o       = level_q;
  assign overrun_o     = overrun_q;
  assign irq_level_o   = (level_q >= LEVEL_TH_L);
  assign irq_timeout_o = irq_tmo_q;
  assign wdg_rst_o     = wdg_rst_q;

endmodule
